hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
Pipeline scheduler for the 5-stage MIPS core. It keeps a 3-entry scoreboard of in-flight register writers in the EX, MEM and WB stages. From that scoreboard it generates the pipeline pause (IF/ID and PC hold), ID/EXE bubble insertion and optional IF/ID flush. It also drives operand-forwarding selects for the ID-stage branch comparator and for the EX-stage ALU operand muxes. It sits beside control_unit in ID and drives the pause inputs of IF_ID, reg_file, ID_EXE and EXE_MEM.

Parameters:
DELAY_SLOT, 1, 1 = branch delay slot architected (no flush on taken); 0 = flush IF/ID on taken branch/jump
CNT_W, 32, width of stall performance counter

Ports:
clk  in  1  clock
rst  in  1  synchronous active-low reset
ext_pause  in  1  external freeze (e.g. memory wait); highest priority
id_valid  in  1  ID holds a real instruction
id_rs  in  5  ID source register 1
id_rt  in  5  ID source register 2
id_rs_used  in  1  ID reads rs
id_rt_used  in  1  ID reads rt
id_reg_we  in  1  ID instruction writes register file
id_reg_dst  in  5  ID destination (post reg_dst_mux)
id_is_load  in  1  ID instruction is a load
id_is_branch  in  1  ID instruction compares rs/rt in ID (branch/jr)
id_taken  in  1  branch/jump taken this cycle (from branch_judge/PCsrc)
pause  out  1  hold PC and IF/ID
id_bubble  out  1  load a NOP into ID/EXE this cycle
if_id_flush  out  1  zero IF/ID on next edge
br_fwd_a  out  2  ID comparator operand rs source: 0 regfile, 1 MEM ALURes, 2 WB data
br_fwd_b  out  2  same for rt
ex_fwd_a  out  2  EX ALU operand rs source, registered: 0 ID/EXE data, 1 MEM ALURes, 2 WB data
ex_fwd_b  out  2  same for rt
stall_cnt  out  CNT_W  count of hazard stall cycles

Behaviour:
- Scoreboard entries EX, MEM, WB each hold {v, we, dst[4:0], ld}.
- A "match" on entry E for source s requires: s used, s != 0, E.v, E.we, and E.dst == s.
- Hazard stall (hz), combinational, requires id_valid and any of:
  - ID source matches EX entry with ld=1 (load-use);
  - id_is_branch and an ID source matches the EX entry (any writer);
  - id_is_branch and an ID source matches the MEM entry with ld=1.
- Outputs, combinational:
  - pause = ext_pause | hz.
  - id_bubble = hz & ~ext_pause.
  - if_id_flush = (DELAY_SLOT==0) & id_valid & id_taken & ~hz & ~ext_pause.
- br_fwd_x, combinational: 1 if the source matches MEM (non-load); else 2 if it matches WB; else 0. Only meaningful when hz=0.
- Clock edge, when rst=0: all entries v=0; ex_fwd_a/b=0; stall_cnt=0.
- Clock edge, when ext_pause=1: scoreboard, ex_fwd and stall_cnt hold.
- Clock edge, otherwise:
  - WB<=MEM; MEM<=EX.
  - EX <= hz ? bubble (v=0) : {id_valid, id_reg_we, id_reg_dst, id_is_load}.
  - ex_fwd_x <= hz ? 0 : (source matches current EX ? 1 : source matches current MEM ? 2 : 0). EX has priority over MEM, so the newest value wins.
  - stall_cnt increments when hz=1 and wraps at all-ones.
- A load in EX never receives ex_fwd=1, because hz precludes it.
- Reset mid-stall: the next cycle has pause=0 (scoreboard empty) and counter 0.
- ext_pause together with hz: no bubble, no count; hz re-evaluates after release.
- Both sources matching different entries: each select resolves independently.
- Latency: every stall cycle costs exactly one pipeline cycle. Load→branch dependency costs 2 cycles; ALU→branch costs 1; load→ALU costs 1; ALU→ALU costs 0.

Test Plan:
- add r1 then add r2,r1,r1 back-to-back → pause=0; next cycle ex_fwd_a=ex_fwd_b=1; stall_cnt=0.
- lw r1 then add r2,r1,r3 → pause=1 and id_bubble=1 for exactly 1 cycle; then ex_fwd_a=2, ex_fwd_b=0; stall_cnt=1.
- add r1 then beq r1,r0 → 1 stall cycle, then br_fwd_a=1; lw r1 then beq r1,r0 → 2 stall cycles, then br_fwd_a=2; stall_cnt=3 total.
- addi r0 followed by add r2,r0,r0 (writer dst=0) → no stall, all fwd selects 0.
- ext_pause=1 for 3 cycles during a load-use hazard → pause=1, id_bubble=0, scoreboard and stall_cnt frozen. After release: 1 bubble, stall_cnt+1.
- DELAY_SLOT=0 with taken beq (no hazard) → if_id_flush=1 for 1 cycle. rst=0 asserted during a stall → next cycle all outputs 0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline scheduler for the 5-stage MIPS core.
// Tracks in-flight register writers in EX/MEM/WB and derives the stall,
// bubble and flush controls plus operand-forwarding selects for the ID
// branch comparator and the EX ALU operand muxes.
module hazard_ctrl #(
  parameter int DELAY_SLOT = 1,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ext_pause,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  input  logic             id_reg_we,
  input  logic [4:0]       id_reg_dst,
  input  logic             id_is_load,
  input  logic             id_is_branch,
  input  logic             id_taken,
  output logic             pause,
  output logic             id_bubble,
  output logic             if_id_flush,
  output logic [1:0]       br_fwd_a,
  output logic [1:0]       br_fwd_b,
  output logic [1:0]       ex_fwd_a,
  output logic [1:0]       ex_fwd_b,
  output logic [CNT_W-1:0] stall_cnt
);

  // Payload of one scoreboard entry; the valid bit lives separately so that
  // only it needs a reset.
  typedef struct packed {
    logic       we;
    logic [4:0] dst;
    logic       ld;
  } sb_data_t;

  localparam logic FLUSH_EN = (DELAY_SLOT == 0);

  // Entry in flight: EX (_p0), MEM (_p1), WB (_p2).
  logic     ex_v_p0, mem_v_p1, wb_v_p2;
  sb_data_t ex_d_p0, mem_d_p1, wb_d_p2;

  logic rs_ex, rt_ex, rs_mem, rt_mem, rs_wb, rt_wb;
  logic hz;

  // A source depends on an entry only if it is read, is not r0, and the
  // entry is a live register writer targeting that register.
  function automatic logic src_match(input logic       used,
                                     input logic [4:0] src,
                                     input logic       v,
                                     input sb_data_t   e);
    return used & (src != 5'd0) & v & e.we & (e.dst == src);
  endfunction

  // Branch comparator source: MEM ALU result when the MEM writer is not a
  // load (its data is not ready yet), else WB write-back data, else regfile.
  function automatic logic [1:0] br_sel(input logic mem_hit,
                                        input logic mem_ld,
                                        input logic wb_hit);
    if (mem_hit && !mem_ld) return 2'd1;
    if (wb_hit)             return 2'd2;
    return 2'd0;
  endfunction

  // ALU operand source one cycle later: the instruction now in EX will be in
  // MEM (select 1), the one now in MEM will be in WB (select 2). The newer
  // producer wins when both match.
  function automatic logic [1:0] ex_sel(input logic ex_hit,
                                        input logic mem_hit);
    if (ex_hit)  return 2'd1;
    if (mem_hit) return 2'd2;
    return 2'd0;
  endfunction

  // Dependency detection and combinational controls.
  always_comb begin
    rs_ex  = src_match(id_rs_used, id_rs, ex_v_p0,  ex_d_p0);
    rt_ex  = src_match(id_rt_used, id_rt, ex_v_p0,  ex_d_p0);
    rs_mem = src_match(id_rs_used, id_rs, mem_v_p1, mem_d_p1);
    rt_mem = src_match(id_rt_used, id_rt, mem_v_p1, mem_d_p1);
    rs_wb  = src_match(id_rs_used, id_rs, wb_v_p2,  wb_d_p2);
    rt_wb  = src_match(id_rt_used, id_rt, wb_v_p2,  wb_d_p2);

    hz = id_valid & ( ((rs_ex | rt_ex) & ex_d_p0.ld)
                    | (id_is_branch & (rs_ex | rt_ex))
                    | (id_is_branch & (rs_mem | rt_mem) & mem_d_p1.ld) );

    pause       = ext_pause | hz;
    id_bubble   = hz & ~ext_pause;
    if_id_flush = FLUSH_EN & id_valid & id_taken & ~hz & ~ext_pause;

    br_fwd_a = br_sel(rs_mem, mem_d_p1.ld, rs_wb);
    br_fwd_b = br_sel(rt_mem, mem_d_p1.ld, rt_wb);
  end

  // Control state: entry valids, registered EX forwarding selects, stall count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ex_v_p0   <= 1'b0;
      mem_v_p1  <= 1'b0;
      wb_v_p2   <= 1'b0;
      ex_fwd_a  <= 2'd0;
      ex_fwd_b  <= 2'd0;
      stall_cnt <= '0;
    end else if (!ext_pause) begin
      // ---- ID -> EX boundary: a stall injects a bubble ----
      ex_v_p0  <= id_valid & ~hz;
      // ---- EX -> MEM -> WB boundaries ----
      mem_v_p1 <= ex_v_p0;
      wb_v_p2  <= mem_v_p1;
      ex_fwd_a <= hz ? 2'd0 : ex_sel(rs_ex, rs_mem);
      ex_fwd_b <= hz ? 2'd0 : ex_sel(rt_ex, rt_mem);
      if (hz) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  // Entry payloads advance with the pipeline; meaningless while valid is low.
  always_ff @(posedge clk) begin
    if (!ext_pause) begin
      ex_d_p0  <= '{we: id_reg_we, dst: id_reg_dst, ld: id_is_load};
      mem_d_p1 <= ex_d_p0;
      wb_d_p2  <= mem_d_p1;
    end
  end

endmodule
